effective_address_unit: RTL and testbench
=========================================

# effective_address_unit

Multi-cycle addressing sequencer that sits directly downstream of the opcode decoder in the M6502 core. It consumes the decoder's addressing mode, index select and access type. It then runs the 6502 operand and effective-address bus cycles: operand fetch, zero-page/pointer wrap, page-cross fix-up, dummy reads, data read/write and read-modify-write. On completion it returns the operand byte, the effective address and the PC increment to the execute logic.

## Interface
- No parameters.
- i_clk  in  1  core clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request; accepted only when o_busy=0.
- i_addressingMode  in  AddressingMode  mode from decoder.
- i_index  in  Index  Index_None/Index_X/Index_Y.
- i_accessType  in  AccessType  Access_Read/Access_Write/Access_ReadWrite.
- i_noData  in  1  stop after address resolution, with no data cycle (JMP/JSR).
- i_pc  in  16  address of first operand byte.
- i_x, i_y  in  8  index registers, sampled at start.
- i_wdata  in  8  store data, sampled at start.
- i_modData  in  8  ALU result for RMW, sampled at end of RMW dummy-write cycle.
- i_rdy  in  1  bus ready; low stalls the current bus cycle.
- i_rdata  in  8  bus read data, sampled at end of a read cycle with i_rdy=1.
- o_busEn  out  1  bus cycle driven this cycle.
- o_addr  out  16  bus address.
- o_rw  out  1  1=read, 0=write.
- o_wdata  out  8  bus write data.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_operand  out  8  data/immediate byte read; held until next done.
- o_ea  out  16  effective address; held until next done.
- o_pcInc  out  2  operand bytes consumed (0..2).

## Operation
- Start is accepted in IDLE only; mode, index, access, noData, pc, x, y and wdata are registered. Start while busy is ignored.
- Index value: X, Y, or 0 for Index_None.
- Bus cycles per mode (i_rdy=1, in order):
  - Implied: none; pcInc 0.
  - Immediate/Relative: read pc -> operand; ea=pc; pcInc 1.
  - ZeroPage: read pc (b); data at {00,b}; pcInc 1.
  - ZeroPageIndexed: read pc (b); dummy read {00,b}; data at {00,b+idx mod 256}; pcInc 1.
  - Absolute: read pc (lo), pc+1 (hi); data at {hi,lo}; pcInc 2.
  - AbsoluteIndexed: lo, hi; if carry from lo+idx or access != Read, dummy read at {hi,(lo+idx)[7:0]}; data at {hi,lo}+idx (16-bit); pcInc 2.
  - IndexedIndirect: read pc (z); dummy read {00,z}; ptr lo {00,z+X}; ptr hi {00,z+X+1}, 8-bit wrap; data at ptr; pcInc 1.
  - IndirectIndexed: read pc (z); ptr lo {00,z}; ptr hi {00,z+1}, 8-bit wrap; fix-up rule as AbsoluteIndexed with Y; pcInc 1.
  - AbsoluteIndirect: lo, hi -> p; ptr lo at p; ptr hi at {p[15:8],p[7:0]+1} (page-wrap bug). No data cycle. ea=ptr; pcInc 2.
- Data phase by access type:
  - Read: one read; o_operand=i_rdata.
  - Write: one write of captured i_wdata.
  - ReadWrite: read v; dummy write v; write i_modData.
- i_noData=1 skips the data phase; o_operand is unchanged.
- States: IDLE, OPLO, OPHI, ZPDUMMY, PTRLO, PTRHI, FIX, DATA, RMWDUMMY, RMWWR.
- i_rdy=0 holds state, o_addr, o_rw and o_wdata; it applies to all bus cycles, including writes.
- Reset, including mid-operation: immediate return to IDLE with no o_done. Reset values: o_addr=0, o_rw=1, o_wdata=0, o_busEn=0, o_busy=0, o_done=0, o_operand=0, o_ea=0, o_pcInc=0.

## Timing
- Start sampled at edge N; first bus cycle occupies cycle N+1.
- o_done is high in the first IDLE cycle after the last bus cycle completes. o_operand, o_ea and o_pcInc are valid from that cycle.
- A new i_start in the o_done cycle is accepted (back-to-back).
- Implied: start at N, o_done at N+1, o_busEn never high.
- o_busEn=0 and o_rw=1 in IDLE; o_busy=1 from N+1 through the last bus cycle.
- Each stall cycle adds exactly one cycle of latency.

## Test plan
- Immediate, pc=0x0200, rdata 0x5A -> one read at 0x0200; done at N+2; operand 0x5A, pcInc 1.
- ZeroPageIndexed, X, b=0xF0, X=0x20 -> reads 0x0200, dummy 0x00F0; data at 0x0010 (wrap).
- AbsoluteIndexed Read, Y, lo=0xFF, hi=0x12, Y=0x01 -> fix-up dummy at 0x1200, data at 0x1300 (4 bus cycles). Same with Y=0x00 -> 3 bus cycles.
- AbsoluteIndirect, p=0x30FF -> ptr lo read at 0x30FF, ptr hi read at 0x3000; no data cycle; ea from those bytes.
- ReadWrite ZeroPage at 0x0044, rdata 0x80, i_modData 0x00 -> read, write 0x80, write 0x00 at 0x0044.
- i_rdy=0 for 2 cycles mid-IndirectIndexed -> address held, done 2 cycles later. Reset asserted mid-op -> IDLE, no done, all outputs at reset values.

Source files
------------

// File: rtl/effective_address_unit.sv
// 6502 operand / effective-address bus sequencer: walks the addressing-mode bus cycles,
// then the data phase, and returns operand, effective address and PC increment.
// Encodings: mode 0 Implied, 1 Immediate, 2 Relative, 3 ZeroPage, 4 ZeroPageIndexed,
// 5 Absolute, 6 AbsoluteIndexed, 7 IndexedIndirect, 8 IndirectIndexed, 9 AbsoluteIndirect;
// index 0 None, 1 X, 2 Y; access 0 Read, 1 Write, 2 ReadWrite.
module effective_address_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_addressingMode,
    input  logic [1:0]  i_index,
    input  logic [1:0]  i_accessType,
    input  logic        i_noData,
    input  logic [15:0] i_pc,
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    input  logic [7:0]  i_wdata,
    input  logic [7:0]  i_modData,
    input  logic        i_rdy,
    input  logic [7:0]  i_rdata,
    output logic        o_busEn,
    output logic [15:0] o_addr,
    output logic        o_rw,
    output logic [7:0]  o_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_operand,
    output logic [15:0] o_ea,
    output logic [1:0]  o_pcInc
);

    localparam logic [3:0] M_IMPLIED   = 4'd0;
    localparam logic [3:0] M_IMMEDIATE = 4'd1;
    localparam logic [3:0] M_RELATIVE  = 4'd2;
    localparam logic [3:0] M_ZP        = 4'd3;
    localparam logic [3:0] M_ZPX       = 4'd4;
    localparam logic [3:0] M_ABS       = 4'd5;
    localparam logic [3:0] M_ABSX      = 4'd6;
    localparam logic [3:0] M_IZX       = 4'd7;
    localparam logic [3:0] M_IZY       = 4'd8;
    localparam logic [3:0] M_IND       = 4'd9;

    localparam logic [1:0] IDX_X      = 2'd1;
    localparam logic [1:0] IDX_Y      = 2'd2;
    localparam logic [1:0] ACC_READ   = 2'd0;
    localparam logic [1:0] ACC_WRITE  = 2'd1;
    localparam logic [1:0] ACC_RMW    = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_OPLO, S_OPHI, S_ZPDUMMY, S_PTRLO, S_PTRHI,
        S_FIX, S_DATA, S_RMWDUMMY, S_RMWWR
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_mode;
    logic [1:0]  r_access;
    logic        r_noData;
    logic [15:0] r_pc;
    logic [7:0]  r_idx;
    logic [7:0]  r_wdata;
    logic [7:0]  r_lo, r_hi, r_plo;
    logic [7:0]  r_rmw, r_mod;
    logic [15:0] r_eff;
    logic [1:0]  r_pcInc;
    logic        r_done;
    logic [7:0]  r_operand;
    logic [15:0] r_ea;
    logic [1:0]  r_pcIncOut;

    logic        w_finish, w_resolve, w_noDataEff, w_needFix;
    logic [15:0] w_resolveAddr, w_finEa, w_addr;
    logic        w_rw;
    logic [7:0]  w_wdata, w_baseLo, w_ptr8, w_ptrPage;
    logic [8:0]  w_sum;

    // Indexed base low byte: operand lo for AbsoluteIndexed, pointer lo for IndirectIndexed.
    assign w_baseLo    = (r_mode == M_IZY) ? r_plo : r_lo;
    assign w_sum       = {1'b0, w_baseLo} + {1'b0, r_idx};
    assign w_needFix   = w_sum[8] | (r_access != ACC_READ);
    assign w_ptr8      = (r_mode == M_IZX) ? (r_lo + r_idx) : r_lo;
    // JMP (ind) never carries into the pointer high byte.
    assign w_ptrPage   = (r_mode == M_IND) ? r_hi : 8'h00;
    assign w_noDataEff = r_noData | (r_mode == M_IND);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_finish      = 1'b0;
        w_resolve     = 1'b0;
        w_resolveAddr = 16'h0000;
        w_finEa       = r_eff;
        w_addr        = 16'h0000;
        w_rw          = 1'b1;
        w_wdata       = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_finEa = r_ea;
                if (i_start) begin
                    if (i_addressingMode == M_IMPLIED) w_finish = 1'b1;
                    else                               w_next   = S_OPLO;
                end
            end
            S_OPLO: begin
                w_addr = r_pc;
                if (i_rdy) begin
                    case (r_mode)
                        M_IMMEDIATE, M_RELATIVE: begin
                            w_finish = 1'b1;
                            w_finEa  = r_pc;
                        end
                        M_ZP: begin
                            w_resolve     = 1'b1;
                            w_resolveAddr = {8'h00, i_rdata};
                        end
                        M_ZPX, M_IZX: w_next = S_ZPDUMMY;
                        M_IZY:        w_next = S_PTRLO;
                        default:      w_next = S_OPHI;
                    endcase
                end
            end
            S_OPHI: begin
                w_addr = r_pc + 16'd1;
                if (i_rdy) begin
                    case (r_mode)
                        M_ABS: begin
                            w_resolve     = 1'b1;
                            w_resolveAddr = {i_rdata, r_lo};
                        end
                        M_ABSX: begin
                            if (w_needFix) w_next = S_FIX;
                            else begin
                                w_resolve     = 1'b1;
                                w_resolveAddr = {i_rdata, w_sum[7:0]};
                            end
                        end
                        M_IND:   w_next   = S_PTRLO;
                        default: w_finish = 1'b1;
                    endcase
                end
            end
            S_ZPDUMMY: begin
                w_addr = {8'h00, r_lo};
                if (i_rdy) begin
                    case (r_mode)
                        M_ZPX: begin
                            w_resolve     = 1'b1;
                            w_resolveAddr = {8'h00, r_lo + r_idx};
                        end
                        M_IZX:   w_next   = S_PTRLO;
                        default: w_finish = 1'b1;
                    endcase
                end
            end
            S_PTRLO: begin
                w_addr = {w_ptrPage, w_ptr8};
                if (i_rdy) w_next = S_PTRHI;
            end
            S_PTRHI: begin
                w_addr = {w_ptrPage, w_ptr8 + 8'd1};
                if (i_rdy) begin
                    if (r_mode == M_IZY) begin
                        if (w_needFix) w_next = S_FIX;
                        else begin
                            w_resolve     = 1'b1;
                            w_resolveAddr = {i_rdata, w_sum[7:0]};
                        end
                    end else begin
                        w_resolve     = 1'b1;
                        w_resolveAddr = {i_rdata, r_plo};
                    end
                end
            end
            S_FIX: begin
                w_addr = {r_hi, w_sum[7:0]};
                if (i_rdy) begin
                    w_resolve     = 1'b1;
                    w_resolveAddr = {r_hi, w_baseLo} + {8'h00, r_idx};
                end
            end
            S_DATA: begin
                w_addr  = r_eff;
                w_rw    = (r_access != ACC_WRITE);
                w_wdata = (r_access == ACC_WRITE) ? r_wdata : 8'h00;
                if (i_rdy) begin
                    if (r_access == ACC_RMW) w_next   = S_RMWDUMMY;
                    else                     w_finish = 1'b1;
                end
            end
            S_RMWDUMMY: begin
                w_addr  = r_eff;
                w_rw    = 1'b0;
                w_wdata = r_rmw;
                if (i_rdy) w_next = S_RMWWR;
            end
            S_RMWWR: begin
                w_addr  = r_eff;
                w_rw    = 1'b0;
                w_wdata = r_mod;
                if (i_rdy) w_finish = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_resolve) begin
            w_finEa = w_resolveAddr;
            if (w_noDataEff) w_finish = 1'b1;
            else             w_next   = S_DATA;
        end
        if (w_finish) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= 4'h0;
            r_access   <= 2'h0;
            r_noData   <= 1'b0;
            r_pc       <= 16'h0000;
            r_idx      <= 8'h00;
            r_wdata    <= 8'h00;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_plo      <= 8'h00;
            r_rmw      <= 8'h00;
            r_mod      <= 8'h00;
            r_eff      <= 16'h0000;
            r_pcInc    <= 2'd0;
            r_done     <= 1'b0;
            r_operand  <= 8'h00;
            r_ea       <= 16'h0000;
            r_pcIncOut <= 2'd0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_mode   <= i_addressingMode;
                    r_access <= i_accessType;
                    r_noData <= i_noData;
                    r_pc     <= i_pc;
                    r_wdata  <= i_wdata;
                    // Indirect modes have a fixed index register regardless of i_index.
                    case (i_addressingMode)
                        M_IZX:   r_idx <= i_x;
                        M_IZY:   r_idx <= i_y;
                        default: r_idx <= (i_index == IDX_X) ? i_x :
                                          (i_index == IDX_Y) ? i_y : 8'h00;
                    endcase
                    case (i_addressingMode)
                        M_IMPLIED:           r_pcInc <= 2'd0;
                        M_ABS, M_ABSX, M_IND: r_pcInc <= 2'd2;
                        default:             r_pcInc <= 2'd1;
                    endcase
                end
                S_OPLO:     if (i_rdy) r_lo  <= i_rdata;
                S_OPHI:     if (i_rdy) r_hi  <= i_rdata;
                S_PTRLO:    if (i_rdy) r_plo <= i_rdata;
                S_PTRHI:    if (i_rdy) r_hi  <= i_rdata;
                S_DATA:     if (i_rdy) r_rmw <= i_rdata;
                S_RMWDUMMY: if (i_rdy) r_mod <= i_modData;
                default: ;
            endcase
            if (w_resolve) r_eff <= w_resolveAddr;
            if (w_finish) begin
                r_ea       <= w_finEa;
                r_pcIncOut <= (r_state == S_IDLE) ? 2'd0 : r_pcInc;
                case (r_state)
                    S_OPLO:  if (r_mode == M_IMMEDIATE || r_mode == M_RELATIVE) r_operand <= i_rdata;
                    S_DATA:  if (r_access != ACC_WRITE) r_operand <= i_rdata;
                    S_RMWWR: r_operand <= r_rmw;
                    default: ;
                endcase
            end
        end
    end

    assign o_busEn   = (r_state != S_IDLE);
    assign o_busy    = (r_state != S_IDLE);
    assign o_addr    = w_addr;
    assign o_rw      = w_rw;
    assign o_wdata   = w_wdata;
    assign o_done    = r_done;
    assign o_operand = r_operand;
    assign o_ea      = r_ea;
    assign o_pcInc   = r_pcIncOut;

endmodule

// File: tb/tb_effective_address_unit.sv
// Randomized bench for effective_address_unit against an integer-arithmetic model of the
// 6502 addressing bus sequence, with a flat 64 KiB memory answering reads.
module tb_effective_address_unit;

    localparam int M_IMP = 0, M_IMM = 1, M_REL = 2, M_ZP = 3, M_ZPX = 4, M_ABS = 5;
    localparam int M_ABSX = 6, M_IZX = 7, M_IZY = 8, M_IND = 9;
    localparam int A_R = 0, A_W = 1, A_RW = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [3:0]  i_addressingMode = '0;
    logic [1:0]  i_index = '0;
    logic [1:0]  i_accessType = '0;
    logic        i_noData = 1'b0;
    logic [15:0] i_pc = '0;
    logic [7:0]  i_x = '0, i_y = '0, i_wdata = '0, i_modData = '0;
    logic        i_rdy = 1'b1;
    logic [7:0]  i_rdata;
    logic        o_busEn, o_rw, o_busy, o_done;
    logic [15:0] o_addr, o_ea;
    logic [7:0]  o_wdata, o_operand;
    logic [1:0]  o_pcInc;

    logic [7:0]  mem [0:65535];
    assign i_rdata = mem[o_addr];

    effective_address_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_addressingMode(i_addressingMode), .i_index(i_index), .i_accessType(i_accessType),
        .i_noData(i_noData), .i_pc(i_pc), .i_x(i_x), .i_y(i_y), .i_wdata(i_wdata),
        .i_modData(i_modData), .i_rdy(i_rdy), .i_rdata(i_rdata),
        .o_busEn(o_busEn), .o_addr(o_addr), .o_rw(o_rw), .o_wdata(o_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_operand(o_operand), .o_ea(o_ea),
        .o_pcInc(o_pcInc)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    logic [24:0] exp_q [$];
    logic [7:0]  e_op = 8'h00;
    logic [15:0] e_ea = 16'h0000;
    logic [1:0]  e_inc = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m(input int a);
        return int'(mem[a & 16'hFFFF]);
    endfunction

    function automatic void rd(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        exp_q.push_back({a16, 1'b1, 8'h00});
    endfunction

    function automatic void wr(input int a, input int d);
        logic [15:0] a16;
        logic [7:0]  d8;
        a16 = 16'(a);
        d8  = 8'(d);
        exp_q.push_back({a16, 1'b0, d8});
    endfunction

    // Expected bus cycles and results, straight from the addressing-mode rules.
    task automatic model(input int mode, isel, acc, nod, pc, x, y, wd, md);
        int idx, lo, hi, z, p, q, ea;
        bit data;
        exp_q.delete();
        data = 0;
        ea = 0;
        idx = (isel == 1) ? x : (isel == 2) ? y : 0;
        e_inc = 2'd1;
        case (mode)
            M_IMP: e_inc = 2'd0;
            M_IMM, M_REL: begin rd(pc); e_op = 8'(m(pc)); e_ea = 16'(pc); end
            M_ZP:  begin rd(pc); ea = m(pc); data = 1; end
            M_ZPX: begin rd(pc); z = m(pc); rd(z); ea = (z + idx) % 256; data = 1; end
            M_ABS: begin
                rd(pc); rd(pc + 1); ea = m(pc + 1) * 256 + m(pc); e_inc = 2'd2; data = 1;
            end
            M_ABSX: begin
                rd(pc); rd(pc + 1); lo = m(pc); hi = m(pc + 1); e_inc = 2'd2;
                if (lo + idx > 255 || acc != A_R) rd(hi * 256 + (lo + idx) % 256);
                ea = (hi * 256 + lo + idx) % 65536; data = 1;
            end
            M_IZX: begin
                rd(pc); z = m(pc); rd(z); p = (z + x) % 256; rd(p); rd((p + 1) % 256);
                ea = m((p + 1) % 256) * 256 + m(p); data = 1;
            end
            M_IZY: begin
                rd(pc); z = m(pc); rd(z); rd((z + 1) % 256);
                lo = m(z); hi = m((z + 1) % 256);
                if (lo + y > 255 || acc != A_R) rd(hi * 256 + (lo + y) % 256);
                ea = (hi * 256 + lo + y) % 65536; data = 1;
            end
            M_IND: begin
                rd(pc); rd(pc + 1); p = m(pc + 1) * 256 + m(pc); e_inc = 2'd2;
                q = (p / 256) * 256 + (p + 1) % 256;
                rd(p); rd(q); e_ea = 16'(m(q) * 256 + m(p));
            end
            default: ;
        endcase
        if (data) begin
            e_ea = 16'(ea);
            if (nod == 0) begin
                case (acc)
                    A_W:  wr(ea, wd);
                    A_RW: begin rd(ea); wr(ea, m(ea)); wr(ea, md); e_op = 8'(m(ea)); end
                    default: begin rd(ea); e_op = 8'(m(ea)); end
                endcase
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (back-to-back ready).
    task automatic run_tx(input int mode, isel, acc, nod, pc, x, y, wd, md,
                          input int spct, sat, sn);
        int cyc, pos, nstall;
        bit done_seen, stall;
        logic [24:0] got;
        model(mode, isel, acc, nod, pc, x, y, wd, md);
        i_addressingMode = 4'(mode); i_index = 2'(isel); i_accessType = 2'(acc);
        i_noData = 1'(nod); i_pc = 16'(pc); i_x = 8'(x); i_y = 8'(y);
        i_wdata = 8'(wd); i_modData = 8'(md); i_start = 1'b1;
        @(negedge i_clk);
        cyc = 1; pos = 0; nstall = 0; done_seen = 0;
        while (!done_seen && cyc < 80) begin
            if (o_done) begin
                done_seen = 1;
                i_start = 1'b0;
                chk("latency", cyc, exp_q.size() + nstall + 1);
                chk("nbus", pos, exp_q.size());
                chk("operand", o_operand, e_op);
                chk("ea", o_ea, e_ea);
                chk("pcInc", o_pcInc, e_inc);
                chk("busy_done", o_busy, 0);
            end else begin
                chk("busy", o_busy, 1);
                // Junk start/operands while busy must be ignored.
                i_start = 1'($urandom_range(1));
                i_addressingMode = 4'($urandom_range(9));
                i_pc = 16'($urandom); i_x = 8'($urandom); i_y = 8'($urandom);
                i_wdata = 8'($urandom);
                if (o_busEn) begin
                    got = o_rw ? {o_addr, 1'b1, 8'h00} : {o_addr, 1'b0, o_wdata};
                    if (pos < exp_q.size()) chk("bus", got, exp_q[pos]);
                    stall = (spct > 0 && int'($urandom_range(99)) < spct) ||
                            (pos == sat && nstall < sn);
                    i_rdy = !stall;
                    if (stall) nstall++; else pos++;
                end
                @(negedge i_clk);
                cyc++;
            end
        end
        chk("done_seen", done_seen, 1);
        i_start = 1'b0;
        i_rdy = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus"}, {o_busEn, o_addr, o_rw, o_wdata}, {1'b0, 16'h0000, 1'b1, 8'h00});
        chk({tag, "_res"}, {o_busy, o_done, o_operand, o_ea, o_pcInc}, 28'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (2) @(negedge i_clk);
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Immediate at 0x0200
        mem[16'h0200] = 8'h5A;
        run_tx(M_IMM, 0, A_R, 0, 'h0200, 0, 0, 0, 0, 0, -1, 0);
        // ZeroPageIndexed X with zero-page wrap
        mem[16'h0200] = 8'hF0;
        run_tx(M_ZPX, 1, A_R, 0, 'h0200, 'h20, 0, 0, 0, 0, -1, 0);
        // AbsoluteIndexed Y, page cross then none
        mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'h12;
        run_tx(M_ABSX, 2, A_R, 0, 'h0200, 0, 1, 0, 0, 0, -1, 0);
        run_tx(M_ABSX, 2, A_R, 0, 'h0200, 0, 0, 0, 0, 0, -1, 0);
        // JMP (ind) page-wrap bug
        mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h30;
        mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12;
        run_tx(M_IND, 0, A_R, 1, 'h0300, 0, 0, 0, 0, 0, -1, 0);
        chk("ind_ea", o_ea, 16'h1234);
        // ReadWrite zero page 0x44
        mem[16'h0200] = 8'h44; mem[16'h0044] = 8'h80;
        run_tx(M_ZP, 0, A_RW, 0, 'h0200, 0, 0, 'h77, 'h00, 0, -1, 0);
        // Write, and an Implied back-to-back
        run_tx(M_ABS, 0, A_W, 0, 'h0200, 0, 0, 'hC3, 0, 0, -1, 0);
        run_tx(M_IMP, 0, A_R, 0, 'h0200, 0, 0, 0, 0, 0, -1, 0);
        // IndirectIndexed with a 2-cycle stall on the pointer-hi read
        mem[16'h0400] = 8'h80;
        run_tx(M_IZY, 0, A_R, 0, 'h0400, 0, 'h10, 0, 0, 0, 2, 2);

        // Reset in the middle of an Absolute read
        i_addressingMode = 4'(M_ABS); i_accessType = 2'(A_R); i_noData = 1'b0;
        i_pc = 16'h0500; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        e_op = 8'h00; e_ea = 16'h0000; e_inc = 2'd0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_done", {o_done, o_busy, o_busEn}, 3'b000);
            @(negedge i_clk);
        end

        for (int t = 0; t < 300; t++) begin
            run_tx($urandom_range(9), $urandom_range(2), $urandom_range(2),
                   ($urandom_range(3) == 0) ? 1 : 0, $urandom_range(65535),
                   $urandom_range(255), $urandom_range(255), $urandom_range(255),
                   $urandom_range(255), 25, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
